ex_alu_arb: RTL and testbench
=============================

Name: ex_alu_arb

Overview:
- Arbitrates the single shared integer ALU between two issue requesters: A (integer pipe) and B (branch/compare pipe).
- Drives the ALU's combinational control and operand inputs and captures its result the same cycle.
- Queues results, with source and tag, in a small result FIFO toward writeback.
- Sits in the execute stage between the issue logic and the ALU/writeback.

Parameters:
- TAG_W, 5, width of the destination/ROB tag carried with each operation
- RES_DEPTH, 2, result FIFO entries (power of two, >=2)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- a_valid  in  1  requester A has an operation
- a_ready  out  1  A's operation accepted this cycle
- a_in1, a_in2  in  64  A operands
- a_unit  in  3  A ALU unit select
- a_op  in  2  A ALU op select
- a_tag  in  TAG_W  A tag
- b_valid, b_ready, b_in1, b_in2, b_unit, b_op, b_tag  same as A, for requester B
- alu_enable  out  1  ALU enable; high only on a grant cycle
- alu_in1, alu_in2  out  64  ALU operands
- alu_unit  out  3  ALU unit select
- alu_op  out  2  ALU op select
- alu_out  in  64  ALU combinational result
- res_valid  out  1  FIFO head valid
- res_ready  in  1  writeback consumes head
- res_data  out  64  head result
- res_tag  out  TAG_W  head tag
- res_src  out  1  head source: 0 = A, 1 = B

Behaviour:
- Reset: asynchronous on rst high.
  - FIFO count, read and write pointers = 0.
  - rr_pri = 0 (A preferred).
  - res_valid = 0; res_data, res_tag, res_src = 0.
  - a_ready = b_ready = 0, alu_enable = 0.
  - Reset mid-operation discards all queued results; no partial state survives.
- space = (count < RES_DEPTH) | (res_valid & res_ready). A full FIFO accepts a push in the same cycle as a pop.
- Grant (combinational):
  - If !space: no grant.
  - Only a_valid: grant A.
  - Only b_valid: grant B.
  - Both valid: grant A if rr_pri == 0, else B.
- a_ready = grant_A, b_ready = grant_B; at most one is high. ready never depends on the requester's own operands.
- On a grant, in the same cycle:
  - alu_* = the granted requester's fields and alu_enable = 1.
  - At the rising edge, {alu_out, tag, src} is written at the write pointer.
- With no grant: alu_enable = 0 and alu_in1, alu_in2, alu_unit, alu_op = 0, so the idle ALU output is 0.
- rr_pri updates only on a contested cycle (both valid and a grant): it becomes the opposite of the winner. Uncontested grants leave rr_pri unchanged.
- Latency: a grant in cycle N gives res_valid in cycle N+1 when the FIFO was empty. Results leave in grant order.
- Pop: on res_valid & res_ready the read pointer advances.
- count update: +1 on push only, -1 on pop only, unchanged on push+pop.
- Pointers wrap modulo RES_DEPTH.
- res_* are driven from the head entry. res_data, res_tag, res_src are don't-care when res_valid = 0, but must be 0 after reset.
- Requesters may drop valid or change their fields without being granted; the arbiter imposes no hold rule on them.

Decomposition:
- Shared package ex_pkg:
  - ALU unit encodings: UNIT_MATH = 0, UNIT_CMP = 1, UNIT_SHIFT = 2, UNIT_LOGIC = 3.
  - SRC_A = 0, SRC_B = 1.
  - TAG_W default.
- One sub-module: ex_res_fifo.
  - Parameterised width and depth; push, pop, full, empty, count.
  - Combinational head read; push-when-full allowed only alongside a pop.
- The arbiter/rr logic stays in ex_alu_arb.

Test Plan:
1. Reset then A only: a_valid=1, in1=5, in2=3, unit=0, op=0, tag=7 -> a_ready=1 and alu_enable=1 that cycle; next cycle res_valid=1, res_data=8, res_tag=7, res_src=0.
2. Contention: A and B both valid for 4 cycles, res_ready=1 -> grants in order A, B, A, B; results in grant order with src 0, 1, 0, 1.
3. Backpressure: res_ready=0, A valid continuously -> exactly RES_DEPTH grants, then a_ready=0 and alu_enable=0 until res_ready=1.
4. Full with simultaneous pop/push: count=RES_DEPTH, res_ready=1, B valid (SUB 10-4) -> b_ready=1 the same cycle, count stays RES_DEPTH, and 6 appears in FIFO order.
5. Uncontested stability: rr_pri=1, A alone granted twice -> rr_pri still 1; the next contested cycle grants B.
6. Async reset mid-stream: assert rst between clock edges while the FIFO holds 2 entries -> res_valid=0 and both readies=0 immediately; after release, a_valid=1 yields res_src=0 with one-cycle latency.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared execute-stage definitions: ALU unit encodings, result source codes
// and the default tag width used by the ALU arbiter and its result FIFO.
package ex_pkg;

  localparam int TAG_W_DFLT = 5;

  // ALU unit select encodings (alu_unit)
  localparam logic [2:0] UNIT_MATH  = 3'd0;
  localparam logic [2:0] UNIT_CMP   = 3'd1;
  localparam logic [2:0] UNIT_SHIFT = 3'd2;
  localparam logic [2:0] UNIT_LOGIC = 3'd3;

  // Result source (res_src)
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/ex_res_fifo.sv
// Result FIFO between the shared ALU and writeback.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, push_data write an entry (accepted when not full, or when full
//                   alongside a pop)
//   pop             consume the head entry (ignored when empty)
//   head_data       combinational head entry; zero while empty
//   full, empty     occupancy flags
//   count           number of stored entries
module ex_res_fifo
  import ex_pkg::*;
#(
  parameter int DATA_W = 70,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  // Control: pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; the empty gate below keeps the head at zero
  // after reset regardless of stale contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ex_alu_arb.sv
// Execute-stage arbiter for the single shared integer ALU.
// Two requesters (A: integer pipe, B: branch/compare pipe) compete for the
// ALU; the winner's operands drive the combinational ALU and its result is
// captured, with tag and source, into a small result FIFO toward writeback.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   a_* / b_*                        requester valid/ready, operands, unit,
//                                    op and tag
//   alu_enable, alu_in1/in2,
//   alu_unit, alu_op                 ALU control/operands (zero when idle)
//   alu_out                          ALU combinational result
//   res_valid/ready, res_data,
//   res_tag, res_src                 result FIFO head toward writeback
module ex_alu_arb
  import ex_pkg::*;
#(
  parameter int TAG_W     = TAG_W_DFLT,
  parameter int RES_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [63:0]      a_in1,
  input  logic [63:0]      a_in2,
  input  logic [2:0]       a_unit,
  input  logic [1:0]       a_op,
  input  logic [TAG_W-1:0] a_tag,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [63:0]      b_in1,
  input  logic [63:0]      b_in2,
  input  logic [2:0]       b_unit,
  input  logic [1:0]       b_op,
  input  logic [TAG_W-1:0] b_tag,
  output logic             alu_enable,
  output logic [63:0]      alu_in1,
  output logic [63:0]      alu_in2,
  output logic [2:0]       alu_unit,
  output logic [1:0]       alu_op,
  input  logic [63:0]      alu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [63:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_src
);

  localparam int ENT_W = 64 + TAG_W + 1;
  localparam int CNT_W = $clog2(RES_DEPTH + 1);

  logic             rr_pri;   // 0: A preferred on contention, 1: B preferred
  logic             grant_a;
  logic             grant_b;
  logic             space;
  logic             res_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] res_count;
  logic [ENT_W-1:0] push_ent;
  logic [ENT_W-1:0] head_ent;
  logic [TAG_W-1:0] grant_tag;
  logic             unused_count;

  // Occupancy is already summarised by fifo_full / fifo_empty.
  assign unused_count = ^res_count;

  assign res_pop = res_valid & res_ready;
  assign space   = ~fifo_full | res_pop;

  // Grant is held off during reset so both readies read zero immediately.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst && space) begin
      if (a_valid && b_valid) begin
        grant_a = ~rr_pri;
        grant_b = rr_pri;
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  assign a_ready    = grant_a;
  assign b_ready    = grant_b;
  assign alu_enable = grant_a | grant_b;

  // Idle ALU inputs are forced to zero so the idle ALU output is zero too.
  always_comb begin
    alu_in1   = '0;
    alu_in2   = '0;
    alu_unit  = '0;
    alu_op    = '0;
    grant_tag = '0;
    if (grant_a) begin
      alu_in1   = a_in1;
      alu_in2   = a_in2;
      alu_unit  = a_unit;
      alu_op    = a_op;
      grant_tag = a_tag;
    end else if (grant_b) begin
      alu_in1   = b_in1;
      alu_in2   = b_in2;
      alu_unit  = b_unit;
      alu_op    = b_op;
      grant_tag = b_tag;
    end
  end

  // Priority flips only when both requested; it points away from the winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_pri <= 1'b0;
    end else if (a_valid && b_valid && (grant_a || grant_b)) begin
      rr_pri <= grant_a;
    end
  end

  assign push_ent = {alu_out, grant_tag, (grant_b ? SRC_B : SRC_A)};

  ex_res_fifo #(
    .DATA_W (ENT_W),
    .DEPTH  (RES_DEPTH)
  ) u_res_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (alu_enable),
    .push_data (push_ent),
    .pop       (res_pop),
    .head_data (head_ent),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (res_count)
  );

  assign res_valid = ~fifo_empty;
  assign res_data  = head_ent[ENT_W-1 -: 64];
  assign res_tag   = head_ent[TAG_W:1];
  assign res_src   = head_ent[0];

endmodule

// File: tb/tb_ex_alu_arb.sv
module tb_ex_alu_arb;
  import ex_pkg::*;

  localparam int TAG_W = 5;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             a_valid, b_valid, a_ready, b_ready;
  logic [63:0]      a_in1, a_in2, b_in1, b_in2;
  logic [2:0]       a_unit, b_unit;
  logic [1:0]       a_op, b_op;
  logic [TAG_W-1:0] a_tag, b_tag;
  logic             alu_enable;
  logic [63:0]      alu_in1, alu_in2, alu_out;
  logic [2:0]       alu_unit;
  logic [1:0]       alu_op;
  logic             res_valid, res_ready, res_src;
  logic [63:0]      res_data;
  logic [TAG_W-1:0] res_tag;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Behavioural ALU used both as the DUT's ALU and by the reference model.
  function automatic logic [63:0] alu_fn(input logic [63:0] x, input logic [63:0] y,
                                         input logic [2:0] unit, input logic [1:0] op);
    case (unit)
      UNIT_MATH:  return op[0] ? x - y : x + y;
      UNIT_CMP:   case (op)
                    2'd0: return {63'd0, x == y};
                    2'd1: return {63'd0, $signed(x) < $signed(y)};
                    2'd2: return {63'd0, x < y};
                    default: return {63'd0, x != y};
                  endcase
      UNIT_SHIFT: case (op)
                    2'd0: return x << y[5:0];
                    2'd1: return x >> y[5:0];
                    default: return $unsigned($signed(x) >>> y[5:0]);
                  endcase
      UNIT_LOGIC: case (op)
                    2'd0: return x & y;
                    2'd1: return x | y;
                    2'd2: return x ^ y;
                    default: return ~(x | y);
                  endcase
      default:    return 64'd0;
    endcase
  endfunction

  assign alu_out = alu_fn(alu_in1, alu_in2, alu_unit, alu_op);

  ex_alu_arb #(.TAG_W(TAG_W), .RES_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_in1(a_in1), .a_in2(a_in2),
    .a_unit(a_unit), .a_op(a_op), .a_tag(a_tag),
    .b_valid(b_valid), .b_ready(b_ready), .b_in1(b_in1), .b_in2(b_in2),
    .b_unit(b_unit), .b_op(b_op), .b_tag(b_tag),
    .alu_enable(alu_enable), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_unit(alu_unit), .alu_op(alu_op), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .res_src(res_src)
  );

  // Reference model: a queue of pending results plus a "B preferred" flag.
  typedef struct {
    logic [63:0]      d;
    logic [TAG_W-1:0] t;
    logic             s;
  } ent_t;

  ent_t mq[$];
  bit   m_b_pref = 1'b0;
  bit   exp_a, exp_b;

  task automatic predict();
    bit room;
    room  = (mq.size() < DEPTH) || (mq.size() > 0 && res_ready);
    exp_a = 1'b0;
    exp_b = 1'b0;
    if (room) begin
      if (a_valid && b_valid) begin
        exp_a = !m_b_pref;
        exp_b = m_b_pref;
      end else begin
        exp_a = a_valid;
        exp_b = b_valid;
      end
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_b_pref = 1'b0;
  endtask

  // One clock: predict with current inputs, update the model at the edge,
  // return on the following falling edge ready for new stimulus.
  task automatic tick();
    ent_t e;
    predict();
    @(posedge clk);
    if (mq.size() > 0 && res_ready) void'(mq.pop_front());
    if (exp_a) begin
      e.d = alu_fn(a_in1, a_in2, a_unit, a_op); e.t = a_tag; e.s = 1'b0;
      mq.push_back(e);
    end else if (exp_b) begin
      e.d = alu_fn(b_in1, b_in2, b_unit, b_op); e.t = b_tag; e.s = 1'b1;
      mq.push_back(e);
    end
    if (a_valid && b_valid && (exp_a || exp_b)) m_b_pref = exp_a;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    a_valid = 0; b_valid = 0;
    a_in1 = 0; a_in2 = 0; a_unit = 0; a_op = 0; a_tag = 0;
    b_in1 = 0; b_in2 = 0; b_unit = 0; b_op = 0; b_tag = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    res_ready = 1; rst = 1;
    a_valid = 1; b_valid = 1; a_in1 = 64'h55; b_in1 = 64'h66;
    model_reset();
    #1;
    n_tests++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin n_fail++;
      $display("FAIL reset_ready: got a=%b b=%b want 0 0", a_ready, b_ready); end
    n_tests++; if (alu_enable !== 1'b0 || alu_in1 !== 64'd0) begin n_fail++;
      $display("FAIL reset_alu: got en=%b in1=%h want 0 0", alu_enable, alu_in1); end
    @(posedge clk); @(negedge clk);
    n_tests++; if (res_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    n_tests++; if (res_data !== 64'd0 || res_tag !== '0 || res_src !== 1'b0) begin n_fail++;
      $display("FAIL reset_res_fields: got d=%h t=%h s=%b want 0", res_data, res_tag, res_src); end
    idle_inputs();
    rst = 0;
    #1;
  endtask

  task automatic test_a_only();
    res_ready = 1;
    a_valid = 1; a_in1 = 5; a_in2 = 3; a_unit = UNIT_MATH; a_op = 0; a_tag = 7;
    #1;
    n_tests++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin n_fail++;
      $display("FAIL a_only_ready: got a=%b b=%b want 1 0", a_ready, b_ready); end
    n_tests++; if (alu_enable !== 1'b1 || alu_in1 !== 64'd5 || alu_in2 !== 64'd3) begin n_fail++;
      $display("FAIL a_only_alu: got en=%b in1=%0d in2=%0d want 1 5 3", alu_enable, alu_in1, alu_in2); end
    tick();
    a_valid = 0;
    #1;
    n_tests++; if (res_valid !== 1'b1 || res_data !== 64'd8) begin n_fail++;
      $display("FAIL a_only_result: got v=%b d=%0d want 1 8", res_valid, res_data); end
    n_tests++; if (res_tag !== 5'd7 || res_src !== SRC_A) begin n_fail++;
      $display("FAIL a_only_tag_src: got t=%0d s=%b want 7 0", res_tag, res_src); end
    tick();
  endtask

  task automatic test_contention();
    res_ready = 1;
    for (int i = 0; i < 4; i++) begin
      a_valid = 1; b_valid = 1;
      a_in1 = 64'($urandom); a_in2 = 64'($urandom); a_unit = UNIT_MATH; a_op = 0; a_tag = 5'(i);
      b_in1 = 64'($urandom); b_in2 = 64'($urandom); b_unit = UNIT_LOGIC; b_op = 2; b_tag = 5'(16 + i);
      #1;
      n_tests++; if (a_ready !== ((i % 2) == 0) || b_ready !== ((i % 2) == 1)) begin n_fail++;
        $display("FAIL contention_grant%0d: got a=%b b=%b want alternating from A", i, a_ready, b_ready); end
      if (i > 0) begin
        n_tests++; if (res_valid !== 1'b1 || res_src !== logic'((i - 1) % 2)) begin n_fail++;
          $display("FAIL contention_src%0d: got v=%b s=%b want 1 %0d", i, res_valid, res_src, (i - 1) % 2); end
      end
      tick();
    end
    idle_inputs();
    #1;
    n_tests++; if (res_valid !== 1'b1 || res_src !== SRC_B || res_tag !== 5'd19) begin n_fail++;
      $display("FAIL contention_last: got v=%b s=%b t=%0d want 1 1 19", res_valid, res_src, res_tag); end
    tick();
  endtask

  task automatic test_backpressure();
    int grants = 0;
    idle_inputs(); res_ready = 1;
    tick(); tick();
    res_ready = 0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      a_valid = 1; a_in1 = 64'($urandom); a_in2 = 64'($urandom); a_unit = UNIT_MATH;
      a_op = 2'($urandom_range(0, 1)); a_tag = 5'(i);
      #1;
      if (a_ready === 1'b1) grants++;
      if (i >= DEPTH) begin
        n_tests++; if (a_ready !== 1'b0 || alu_enable !== 1'b0 || alu_in1 !== 64'd0) begin n_fail++;
          $display("FAIL backpressure_stall%0d: got rdy=%b en=%b in1=%h want 0 0 0", i, a_ready, alu_enable, alu_in1); end
      end
      tick();
    end
    n_tests++; if (grants !== DEPTH) begin n_fail++;
      $display("FAIL backpressure_grants: got %0d want %0d", grants, DEPTH); end
  endtask

  task automatic test_full_push_pop();
    a_valid = 0; res_ready = 1;
    b_valid = 1; b_in1 = 10; b_in2 = 4; b_unit = UNIT_MATH; b_op = 1; b_tag = 19;
    #1;
    n_tests++; if (b_ready !== 1'b1 || res_valid !== 1'b1) begin n_fail++;
      $display("FAIL full_pushpop_ready: got b=%b v=%b want 1 1", b_ready, res_valid); end
    tick();
    idle_inputs();
    for (int k = 0; k < DEPTH + 1; k++) begin
      #1;
      n_tests++; if (res_valid !== (k < DEPTH)) begin n_fail++;
        $display("FAIL full_drain_valid%0d: got %b want %b", k, res_valid, k < DEPTH); end
      if (k < DEPTH && mq.size() > 0) begin
        n_tests++; if (res_data !== mq[0].d || res_tag !== mq[0].t || res_src !== mq[0].s) begin n_fail++;
          $display("FAIL full_drain_entry%0d: got d=%h t=%0d s=%b want d=%h t=%0d s=%b",
                   k, res_data, res_tag, res_src, mq[0].d, mq[0].t, mq[0].s); end
      end
      if (k == DEPTH - 1) begin
        n_tests++; if (res_data !== 64'd6 || res_src !== SRC_B || res_tag !== 5'd19) begin n_fail++;
          $display("FAIL full_sub_result: got d=%0d s=%b t=%0d want 6 1 19", res_data, res_src, res_tag); end
      end
      tick();
    end
  endtask

  task automatic test_rr_stability();
    res_ready = 1;
    a_valid = 1; b_valid = 1; a_tag = 1; b_tag = 2;
    #1;
    n_tests++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin n_fail++;
      $display("FAIL rr_first_contest: got a=%b b=%b want 1 0", a_ready, b_ready); end
    tick();
    b_valid = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_tests++; if (a_ready !== 1'b1) begin n_fail++;
        $display("FAIL rr_uncontested%0d: got a=%b want 1", i, a_ready); end
      tick();
    end
    b_valid = 1;
    #1;
    n_tests++; if (a_ready !== 1'b0 || b_ready !== 1'b1) begin n_fail++;
      $display("FAIL rr_kept_pri: got a=%b b=%b want 0 1", a_ready, b_ready); end
    tick();
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_async_reset();
    logic [63:0] x, y;
    res_ready = 0;
    a_valid = 1; a_unit = UNIT_MATH; a_op = 0;
    for (int i = 0; i < 2; i++) begin
      a_in1 = 64'($urandom); a_in2 = 64'($urandom); a_tag = 5'(20 + i);
      tick();
    end
    res_ready = 1; b_valid = 1;
    #2;
    rst = 1;
    #1;
    n_tests++; if (res_valid !== 1'b0 || a_ready !== 1'b0 || b_ready !== 1'b0) begin n_fail++;
      $display("FAIL async_reset_now: got v=%b a=%b b=%b want 0 0 0", res_valid, a_ready, b_ready); end
    model_reset();
    @(negedge clk);
    rst = 0; b_valid = 0;
    x = 64'($urandom); y = 64'($urandom);
    a_valid = 1; a_in1 = x; a_in2 = y; a_unit = UNIT_MATH; a_op = 0; a_tag = 3;
    #1;
    n_tests++; if (a_ready !== 1'b1 || res_valid !== 1'b0) begin n_fail++;
      $display("FAIL async_after_grant: got a=%b v=%b want 1 0", a_ready, res_valid); end
    tick();
    a_valid = 0;
    #1;
    n_tests++; if (res_valid !== 1'b1 || res_src !== SRC_A || res_tag !== 5'd3 || res_data !== x + y) begin n_fail++;
      $display("FAIL async_after_result: got v=%b s=%b t=%0d d=%h want 1 0 3 %h",
               res_valid, res_src, res_tag, res_data, x + y); end
    tick();
  endtask

  task automatic test_random();
    logic [63:0] exp_in1;
    for (int i = 0; i < 400; i++) begin
      a_valid = 1'($urandom); b_valid = 1'($urandom);
      a_in1 = {$urandom, $urandom}; a_in2 = {$urandom, $urandom};
      b_in1 = {$urandom, $urandom}; b_in2 = {$urandom, $urandom};
      a_unit = 3'($urandom_range(0, 3)); b_unit = 3'($urandom_range(0, 3));
      a_op = 2'($urandom); b_op = 2'($urandom);
      a_tag = 5'($urandom); b_tag = 5'($urandom);
      res_ready = ($urandom_range(0, 9) < 6);
      #1;
      predict();
      exp_in1 = exp_a ? a_in1 : (exp_b ? b_in1 : 64'd0);
      n_tests++; if (a_ready !== exp_a || b_ready !== exp_b || alu_enable !== (exp_a | exp_b)) begin n_fail++;
        $display("FAIL rand_grant%0d: got a=%b b=%b en=%b want %b %b %b",
                 i, a_ready, b_ready, alu_enable, exp_a, exp_b, exp_a | exp_b); end
      n_tests++; if (alu_in1 !== exp_in1) begin n_fail++;
        $display("FAIL rand_alu_in1_%0d: got %h want %h", i, alu_in1, exp_in1); end
      n_tests++; if (res_valid !== (mq.size() > 0)) begin n_fail++;
        $display("FAIL rand_res_valid%0d: got %b want %b", i, res_valid, mq.size() > 0); end
      if (mq.size() > 0) begin
        n_tests++; if (res_data !== mq[0].d || res_tag !== mq[0].t || res_src !== mq[0].s) begin n_fail++;
          $display("FAIL rand_head%0d: got d=%h t=%0d s=%b want d=%h t=%0d s=%b",
                   i, res_data, res_tag, res_src, mq[0].d, mq[0].t, mq[0].s); end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_a_only();
    test_contention();
    test_backpressure();
    test_full_push_pop();
    test_rr_stability();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
